// File: rtl/adder_stream_pkg.sv
// rtl/adder_stream_pkg.sv - shared state encoding and saturation limits for adder_stream
//
// Purpose: FSM state constants and helper functions used by adder_stream.
// Ports:   none (package).
// Build:   ADDER_STREAM_SAT_EN selects the saturating signed adder in adder_stream.

package adder_stream_pkg;

  typedef logic [0:0] state_t;

  localparam state_t INIT = 1'b0;
  localparam state_t RUN  = 1'b1;

  // Two's complement saturation limits; callers keep the low width bits.
  function automatic logic [63:0] sat_pos(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_neg(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/adder_stream_fifo.sv
// rtl/adder_stream_fifo.sv - result FIFO with occupancy count for adder_stream
//
// Purpose: DEPTH-entry FIFO of WIDTH-bit words. The head word is shown on
//          pop_data while non-empty; when empty, pop_data holds the last word
//          popped (zero after reset).
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (clears pointers, level, hold)
//   push       in   write push_data this cycle (caller guarantees space)
//   push_data  in   WIDTH-bit word to write
//   pop        in   remove head word this cycle (ignored when empty)
//   pop_data   out  head word, or last popped word when empty
//   level      out  number of stored words, 0..DEPTH

module adder_stream_fifo #(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic [WIDTH-1:0] hold_q;
  logic             do_pop;

  assign do_pop = pop && (level_q != '0);

  // Storage carries no reset: only entries below level_q are ever shown.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      hold_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        hold_q <= mem[rd_ptr];
      end
      case ({push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign pop_data = (level_q != '0) ? mem[rd_ptr] : hold_q;
  assign level    = level_q;

endmodule

// File: rtl/adder_stream.sv
// rtl/adder_stream.sv - buffered valid/ready adder with registered add stage and result FIFO
//
// Purpose: accepts operand pairs, adds them in one registered stage and queues
//          {carry,sum} results in a DEPTH-entry FIFO drained over valid/ready.
//          Define ADDER_STREAM_SAT_EN for signed saturating addition, where
//          out_carry flags signed overflow; otherwise unsigned wrap with carry-out.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands present
//   in_ready   out  operands accepted at the next edge if in_valid
//   in_a/in_b  in   WIDTH-bit operands
//   out_valid  out  result present at FIFO head
//   out_ready  in   consumer takes the head result
//   out_sum    out  WIDTH-bit result
//   out_carry  out  carry-out (overflow flag in saturating build)
//   level      out  FIFO occupancy

module adder_stream #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic [LW-1:0]    level
);

  import adder_stream_pkg::*;

  typedef struct packed {
    logic             carry;
    logic [WIDTH-1:0] sum;
  } result_t;

  state_t        state;
  result_t       add_res;
  result_t       stage_q;
  result_t       head;
  logic          stage_valid;
  logic          accept;
  logic          pop;
  logic [LW:0]   credit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
    end else begin
      case (state)
        INIT:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // The stage entry is counted as already occupying a FIFO slot, so in_ready
  // depends only on registers and never on out_ready.
  assign credit   = {1'b0, level} + (LW + 1)'(stage_valid);
  assign in_ready = (state == RUN) && (credit < (LW + 1)'(DEPTH));
  assign accept   = in_valid && in_ready;

`ifdef ADDER_STREAM_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos(WIDTH));
  localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg(WIDTH));

  logic [WIDTH-1:0] raw;
  logic             ovf;

  // Signed overflow: operands share a sign that the wrapped sum does not.
  always_comb begin
    raw           = in_a + in_b;
    ovf           = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (raw[WIDTH-1] != in_a[WIDTH-1]);
    add_res.carry = ovf;
    add_res.sum   = ovf ? (in_a[WIDTH-1] ? SAT_NEG : SAT_POS) : raw;
  end
`else
  always_comb begin
    add_res = result_t'({1'b0, in_a} + {1'b0, in_b});
  end
`endif

  // A captured result always moves into the FIFO on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_q     <= '0;
    end else begin
      stage_valid <= accept;
      if (accept) begin
        stage_q <= add_res;
      end
    end
  end

  assign pop = out_valid && out_ready;

  adder_stream_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (stage_valid),
    .push_data (stage_q),
    .pop       (pop),
    .pop_data  (head),
    .level     (level)
  );

  assign out_valid = (level != '0);
  assign out_sum   = head.sum;
  assign out_carry = head.carry;

endmodule

// File: tb/tb_adder_stream.sv
// tb/tb_adder_stream.sv - self-checking bench for adder_stream (WIDTH=8, DEPTH=4)

module tb_adder_stream;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int LW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_sum;
  logic          out_carry;
  logic [LW-1:0] level;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;
  logic [W:0] exp_q [$];

  always #5 clk = ~clk;

  adder_stream #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .level     (level)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: {carry,sum} from integer arithmetic on the operand values.
  function automatic logic [W:0] ref_add(input int a, input int b);
`ifdef ADDER_STREAM_SAT_EN
    int sa, sb, s;
    int maxv, minv;
    maxv = 2 ** (W - 1) - 1;
    minv = -(2 ** (W - 1));
    sa = (a >= 2 ** (W - 1)) ? a - 2 ** W : a;
    sb = (b >= 2 ** (W - 1)) ? b - 2 ** W : b;
    s  = sa + sb;
    if (s > maxv) return {1'b1, W'(maxv)};
    if (s < minv) return {1'b1, W'(minv)};
    return {1'b0, W'(s)};
`else
    int s;
    s = a + b;
    return (W + 1)'(s);
`endif
  endfunction

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b0, {(W-1){1'b1}}};
      3:       v = {1'b1, {(W-1){1'b0}}};
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // Scoreboard: handshakes seen at the falling edge fire on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("sb_result", {out_carry, out_sum}, exp_q.pop_front());
        pop_cnt++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_add(int'(in_a), int'(in_b)));
        acc_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int guard;
    int base;
    logic [W:0] exp_t2;

    // 1. reset state and release
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_carry", out_carry, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t1_rdy_first", in_ready, 0);
    check("t1_ov_first", out_valid, 0);
    check("t1_lvl_first", level, 0);
    @(negedge clk);
    check("t1_rdy_second", in_ready, 1);
    check("t1_ov_second", out_valid, 0);
    check("t1_lvl_second", level, 0);

    // 2. single transaction latency and value
    @(posedge clk); #1;
`ifdef ADDER_STREAM_SAT_EN
    in_a = 8'd100; in_b = 8'd50; exp_t2 = {1'b1, 8'd127};
`else
    in_a = 8'd200; in_b = 8'd100; exp_t2 = {1'b1, 8'd44};
`endif
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("t2_in_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("t2_ov_k", out_valid, 0);
    @(negedge clk);
    check("t2_ov_k1", out_valid, 1);
    check("t2_result", {out_carry, out_sum}, exp_t2);
    @(negedge clk);
    check("t2_ov_after", out_valid, 0);
    check("t2_lvl_after", level, 0);

    // 3. fill to full with out_ready low, then drain in order
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1;
    i = 1; guard = 0;
    while (i <= 4 && guard < 50) begin
      @(negedge clk); guard++;
      if (in_ready) i++;
      @(posedge clk); #1 in_a = W'(i); in_b = W'(i);
    end
    @(negedge clk);
    check("t3_rdy_full", in_ready, 0);
    @(negedge clk);
    check("t3_lvl_full", level, D);
    check("t3_rdy_stall", in_ready, 0);
    base = pop_cnt;
    @(posedge clk); #1 out_ready = 1'b1;
    guard = 0;
    while (i <= 6 && guard < 50) begin
      @(negedge clk); guard++;
      if (in_ready) i++;
      @(posedge clk); #1 in_a = W'(i); in_b = W'(i);
    end
    in_valid = 1'b0;
    guard = 0;
    while (pop_cnt - base < 6 && guard < 50) begin
      @(negedge clk); guard++;
    end
    repeat (2) @(negedge clk);
    check("t3_pops", pop_cnt - base, 6);
    check("t3_lvl_empty", level, 0);

    // 4. streaming with continuous valid and ready
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b1; in_a = pick_operand(); in_b = pick_operand();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c >= 2) check("t4_ov", out_valid, 1);
      check("t4_lvl_le1", level <= 1, 1);
      check("t4_rdy", in_ready, 1);
      @(posedge clk); #1 in_a = pick_operand(); in_b = pick_operand();
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("t4_drained", exp_q.size(), 0);
    check("t4_lvl_end", level, 0);

    // 5. asynchronous reset with level 3 and the stage loaded
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_a = 8'd7; in_b = 8'd9;
    i = 0; guard = 0;
    while (i < 4 && guard < 50) begin
      @(negedge clk); guard++;
      if (in_ready) i++;
      @(posedge clk); #1 in_a = pick_operand(); in_b = pick_operand();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_lvl_pre", level, 3);
    check("t5_rdy_pre", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_ov_async", out_valid, 0);
    check("t5_lvl_async", level, 0);
    check("t5_rdy_async", in_ready, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("t5_no_stale", out_valid, 0);
    end

    // 6. random valid/ready traffic
    base = acc_cnt;
    guard = 0;
    while (acc_cnt - base < 1000 && guard < 20000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = pick_operand();
      in_b      = pick_operand();
      out_ready = ($urandom_range(0, 2) != 0);
      guard++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("t6_accepts", acc_cnt - base, 1000);
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 100) begin
      @(negedge clk); guard++;
    end
    repeat (3) @(negedge clk);
    check("t6_drained", exp_q.size(), 0);
    check("t6_lvl_end", level, 0);
    check("t6_ov_end", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
